// File: rtl/mac_seq.sv
// Vector dot-product sequencer.
// Feeds operand pairs to an external multiply-accumulator, then scales
// and saturates the final sum to a signed 8-bit result.
module mac_seq #(
   parameter int LEN_W = 8,
   parameter int SHIFT = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    strt,
   input  logic [LEN_W-1:0]        len,
   input  logic signed [7:0]       a_in,
   input  logic signed [7:0]       b_in,
   input  logic                    in_vld,
   output logic                    in_rdy,
   output logic signed [7:0]       mac_a,
   output logic signed [7:0]       mac_b,
   output logic                    mac_clr_n,
   input  logic signed [25:0]      mac_acc,
   output logic signed [7:0]       rslt,
   output logic                    done,
   output logic                    busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_RSLT  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
   localparam logic signed [25:0] SAT_MAX = 26'sd127;
   localparam logic signed [25:0] SAT_MIN = -26'sd128;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [LEN_W-1:0]        r_len;
   logic [LEN_W-1:0]        w_len_next;
   logic [LEN_W-1:0]        r_cnt;
   logic [LEN_W-1:0]        w_cnt_next;
   logic signed [7:0]       r_rslt;
   logic                    r_done;
   logic signed [25:0]      w_shifted;
   logic signed [7:0]       w_sat;

   // Scale the final sum (arithmetic shift floors toward -inf) and clamp to 8 bits.
   always_comb begin
      w_shifted = mac_acc >>> SHIFT;
      if (w_shifted > SAT_MAX) begin
         w_sat = 8'sd127;
      end else if (w_shifted < SAT_MIN) begin
         w_sat = -8'sd128;
      end else begin
         w_sat = w_shifted[7:0];
      end
   end

   // Next-state logic and all sequencer outputs; stalls in ACCUM feed zeros.
   always_comb begin
      w_state_next = r_state;
      w_len_next   = r_len;
      w_cnt_next   = r_cnt;
      in_rdy       = 1'b0;
      mac_clr_n    = 1'b0;
      mac_a        = 8'sd0;
      mac_b        = 8'sd0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (strt) begin
               if (len != '0) begin
                  w_len_next   = len;
                  w_cnt_next   = '0;
                  w_state_next = S_ACCUM;
               end else begin
                  w_state_next = S_RSLT;
               end
            end
         end
         S_ACCUM: begin
            mac_clr_n = 1'b1;
            in_rdy    = 1'b1;
            if (in_vld) begin
               mac_a      = a_in;
               mac_b      = b_in;
               w_cnt_next = r_cnt + LEN_ONE;
               if (r_cnt == r_len - LEN_ONE) begin
                  w_state_next = S_RSLT;
               end
            end
         end
         S_RSLT: begin
            mac_clr_n    = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State, captured length and pair counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_len   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_len   <= w_len_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Register the result when leaving RSLT; done pulses for that one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rslt <= 8'sd0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_RSLT);
         if (r_state == S_RSLT) begin
            r_rslt <= w_sat;
         end
      end
   end

   assign rslt = r_rslt;
   assign done = r_done;

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of vector-length input; maximum vector length is 2^LEN_W-1.
REQ-002 Parameter SHIFT, default 7: arithmetic right-shift applied to the final accumulator before saturation.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 strt  input  1  start request; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of operand pairs to accumulate; captured when strt is accepted.
REQ-007 a_in, b_in  input  signed 8 each  operand pair from the upstream source.
REQ-008 in_vld  input  1  a_in/b_in hold a valid pair.
REQ-009 in_rdy  output  1  sequencer accepts a pair this cycle; a transfer occurs when in_vld && in_rdy.
REQ-010 mac_a, mac_b  output  signed 8 each  operands driven to the downstream multiply-accumulator.
REQ-011 mac_clr_n  output  1  clear control to the multiply-accumulator (0 = accumulator loads 0 next edge).
REQ-012 mac_acc  input  signed 26  current multiply-accumulator value.
REQ-013 rslt  output  signed 8  scaled, saturated dot-product result.
REQ-014 done  output  1  one-cycle pulse; rslt is valid in the same cycle.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and RSLT.
REQ-017 The multiply-accumulator contract SHALL be: each posedge, acc <= mac_clr_n ? acc + mac_a*mac_b : 0.
REQ-018 IDLE SHALL drive mac_clr_n=0, mac_a=mac_b=0 and in_rdy=0.
REQ-019 IDLE with strt=1 and len!=0 SHALL capture len, clear the pair counter and move to ACCUM.
REQ-020 IDLE with strt=1 and len==0 SHALL move directly to RSLT.
REQ-021 ACCUM SHALL drive mac_clr_n=1 and in_rdy=1.
REQ-022 ACCUM SHALL drive mac_a/mac_b combinationally equal to a_in/b_in when in_vld=1, and to 0 otherwise, so that stall cycles add nothing.
REQ-023 Each transfer SHALL increment the pair counter.
REQ-024 The transfer at which the pair counter equals captured len-1 SHALL move the FSM to RSLT; no further pairs are accepted.
REQ-025 RSLT SHALL last exactly one cycle and SHALL drive mac_clr_n=1, mac_a=mac_b=0 and in_rdy=0.
REQ-026 In RSLT, mac_acc holds the final sum; at the edge leaving RSLT the block SHALL register rslt = sat8(mac_acc >>> SHIFT) and set done=1, then return to IDLE.
REQ-027 The shift SHALL be arithmetic (floor toward -inf).
REQ-028 sat8 SHALL clamp to +127 when the shifted value exceeds 127 and to -128 when it is below -128.
REQ-029 done SHALL be high for exactly one cycle; rslt SHALL hold its value until the next done.
REQ-030 Latency SHALL be: done high 1 cycle after RSLT, which directly follows the last transfer (len!=0) or the strt cycle (len==0).
REQ-031 strt while busy=1 SHALL be ignored, with no effect on len or the counter.
REQ-032 in_vld while in_rdy=0 SHALL not be consumed; the source holds its data.
REQ-033 The pair counter SHALL be LEN_W bits wide and SHALL NOT wrap, because len is bounded by 2^LEN_W-1.

Reset
REQ-034 rst_n low SHALL asynchronously force: state IDLE, counter 0, captured len 0, rslt 0, done 0; busy, in_rdy, mac_a, mac_b and mac_clr_n then follow the IDLE values.
REQ-035 Reset mid-ACCUM SHALL abandon the operation with no done pulse; the first strt after reset release SHALL start a clean accumulation, because IDLE held mac_clr_n=0.

Verification
REQ-036 len=1, pair (64,64), in_vld continuous -> done exactly 2 cycles after the transfer edge, rslt=32.
REQ-037 len=4, four pairs (127,127) -> sum 64516, shifted value 504, rslt=127 (positive saturation).
REQ-038 len=2, two pairs (-128,127) -> sum -32512, shifted value -254, rslt=-128; then len=1 pair (-1,1) -> rslt=-1 (floor shift).
REQ-039 len=3, pairs (10,20),(30,-5),(7,7) with in_vld low for 2 cycles between each pair -> mac_a/mac_b=0 during gaps, sum 99, rslt=0; the same vector with no gaps gives an identical rslt.
REQ-040 strt with len=0 -> done 2 cycles after strt, rslt=0, in_rdy never asserted; strt pulsed during ACCUM has no effect.
REQ-041 rst_n asserted after 2 of 4 transfers -> no done pulse, all outputs at reset values; a new len=1 (2,64) run gives rslt=1.
